// File: rtl/spi_master_multi.sv
// ----------------------------------------------------------------------------
// SpiMasterMulti : single-word SPI master with several active-low slave selects
//
// One transfer moves DATA_W bits out on MASTER_MOSI and DATA_W bits in from
// MASTER_MISO. The mode (cpol/cpha), bit order, SCLK half period and target
// slave are captured when a transfer is accepted, so the inputs are free to
// change while the transfer runs.
//
// Ports
//   GCLK         system clock, everything runs on its rising edge
//   RST          asynchronous, active-high reset
//   st           start request, level sampled while idle
//   cpol, cpha   SPI mode bits
//   lsb_first    1 = LSB first, 0 = MSB first (both directions)
//   clk_div      SCLK half period in GCLK cycles (0 behaves as 1)
//   ss_sel       index of the slave to select (out of range = no select)
//   tx_data      word to send
//   rx_data      last received word, updated together with done
//   busy         transfer in progress
//   done         one-cycle completion pulse
//   MASTER_SCLK  SPI clock
//   MASTER_MOSI  master data out (0 while idle)
//   MASTER_MISO  master data in
//   MASTER_SS    slave selects, active-low
// ----------------------------------------------------------------------------
module spi_master_multi #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4
) (
   input  logic              GCLK,
   input  logic              RST,
   input  logic              st,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [7:0]        clk_div,
   input  logic [2:0]        ss_sel,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              MASTER_SCLK,
   output logic              MASTER_MOSI,
   input  logic              MASTER_MISO,
   output logic [NUM_SS-1:0] MASTER_SS
);

   // A transfer has exactly 2*DATA_W SCLK edges; the edge counter only
   // needs to reach 2*DATA_W-1, the edge that ends the shifting phase.
   localparam int EW = $clog2(2 * DATA_W);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      LEAD,
      XFER,
      TRAIL
   } stateT;

   stateT             state;
   logic [7:0]        halfPer;
   logic [7:0]        halfCnt;
   logic [EW-1:0]     edgeCnt;
   logic              cphaL;
   logic              lsbL;
   logic [DATA_W-1:0] txShift;
   logic [DATA_W-1:0] rxShift;

   logic              halfDone;
   logic              leadingEdge;
   logic              lastEdge;
   logic              txBit;
   logic [DATA_W-1:0] txNext;
   logic [DATA_W-1:0] rxNext;
   logic              acceptBit;
   logic [DATA_W-1:0] acceptRest;

   // Select pattern for a slave index: every line high except the chosen
   // one; an index with no matching line leaves all of them high.
   function automatic logic [NUM_SS-1:0] selMask(input logic [2:0] idx);
      selMask = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (idx == i[2:0]) begin
            selMask[i] = 1'b0;
         end
      end
   endfunction

   // Timing helpers. halfDone marks the last GCLK cycle of a half period.
   // edgeCnt holds the number of SCLK edges already made, so the edge
   // about to happen is leading (odd) when that count is even.
   assign halfDone    = (halfCnt == halfPer - 8'd1);
   assign leadingEdge = ~edgeCnt[0];
   assign lastEdge    = (edgeCnt == LAST_EDGE);

   // Shift-register views for both bit orders. The accept-time versions
   // work straight from the inputs because the latched copies are not
   // valid until the cycle after acceptance.
   assign txBit      = lsbL ? txShift[0] : txShift[DATA_W-1];
   assign txNext     = lsbL ? {1'b0, txShift[DATA_W-1:1]} : {txShift[DATA_W-2:0], 1'b0};
   assign rxNext     = lsbL ? {MASTER_MISO, rxShift[DATA_W-1:1]} : {rxShift[DATA_W-2:0], MASTER_MISO};
   assign acceptBit  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
   assign acceptRest = lsb_first ? {1'b0, tx_data[DATA_W-1:1]} : {tx_data[DATA_W-2:0], 1'b0};

   // Main controller. IDLE waits for st and latches the whole transfer
   // setup; LEAD gives the slave one half period of select-to-clock setup;
   // XFER produces the 2*DATA_W SCLK edges, shifting MOSI and sampling MISO
   // on the edges dictated by cpha; TRAIL holds select for one more half
   // period before releasing it and publishing the received word.
   // With cpha=0 the first bit must already be on MOSI when select drops,
   // so it is loaded at acceptance and only the remaining bits are shifted
   // on trailing edges. With cpha=1 every bit, including the first, is
   // driven by a leading edge.
   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         rx_data     <= '0;
         MASTER_SCLK <= 1'b0;
         MASTER_MOSI <= 1'b0;
         MASTER_SS   <= '1;
         halfPer     <= 8'd1;
         halfCnt     <= 8'd0;
         edgeCnt     <= '0;
         cphaL       <= 1'b0;
         lsbL        <= 1'b0;
         txShift     <= '0;
         rxShift     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               MASTER_SCLK <= cpol;
               MASTER_MOSI <= 1'b0;
               if (st) begin
                  state       <= LEAD;
                  busy        <= 1'b1;
                  cphaL       <= cpha;
                  lsbL        <= lsb_first;
                  halfPer     <= (clk_div == 8'd0) ? 8'd1 : clk_div;
                  halfCnt     <= 8'd0;
                  edgeCnt     <= '0;
                  rxShift     <= '0;
                  MASTER_SS   <= selMask(ss_sel);
                  MASTER_MOSI <= cpha ? 1'b0 : acceptBit;
                  txShift     <= cpha ? tx_data : acceptRest;
               end
            end
            LEAD: begin
               if (halfDone) begin
                  state   <= XFER;
                  halfCnt <= 8'd0;
               end else begin
                  halfCnt <= halfCnt + 8'd1;
               end
            end
            XFER: begin
               if (halfDone) begin
                  halfCnt     <= 8'd0;
                  MASTER_SCLK <= ~MASTER_SCLK;
                  edgeCnt     <= edgeCnt + EW'(1);
                  if (cphaL ? leadingEdge : (!leadingEdge && !lastEdge)) begin
                     MASTER_MOSI <= txBit;
                     txShift     <= txNext;
                  end
                  if (cphaL ? !leadingEdge : leadingEdge) begin
                     rxShift <= rxNext;
                  end
                  if (lastEdge) begin
                     state <= TRAIL;
                  end
               end else begin
                  halfCnt <= halfCnt + 8'd1;
               end
            end
            TRAIL: begin
               if (halfDone) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  rx_data     <= rxShift;
                  MASTER_SS   <= '1;
                  MASTER_MOSI <= 1'b0;
               end else begin
                  halfCnt <= halfCnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// ----------------------------------------------------------------------------
// Testbench for spi_master_multi (DATA_W=8, NUM_SS=4).
// A behavioural SPI slave drives MISO from its own word and rebuilds the
// word it sees on MOSI; expected results come from the transfer rules:
// timing from the half period, select pattern from the slave index, data
// from the slave word (or tx word when MISO is looped back to MOSI).
// ----------------------------------------------------------------------------
module tb_spi_master_multi;

   localparam int DW  = 8;
   localparam int NSS = 4;

   logic           GCLK = 1'b0;
   logic           RST = 1'b0;
   logic           st = 1'b0;
   logic           cpol = 1'b0;
   logic           cpha = 1'b0;
   logic           lsb_first = 1'b0;
   logic [7:0]     clk_div = 8'd1;
   logic [2:0]     ss_sel = 3'd0;
   logic [DW-1:0]  tx_data = '0;
   logic [DW-1:0]  rx_data;
   logic           busy;
   logic           done;
   logic           MASTER_SCLK;
   logic           MASTER_MOSI;
   logic           MASTER_MISO;
   logic [NSS-1:0] MASTER_SS;

   int totalChecks = 0;
   int badChecks = 0;

   // Slave model state
   logic          loopMode = 1'b0;
   logic          slvMiso = 1'b0;
   logic [DW-1:0] slvWord = '0;
   logic          slvCpha = 1'b0;
   logic          slvLsb = 1'b0;
   int            slvSent = 0;
   int            sclkEdges = 0;
   int            mosiCnt = 0;
   logic [DW-1:0] mosiSeen = '0;
   logic          prevBusy = 1'b0;
   logic          prevSclk = 1'b0;
   logic          isLeading = 1'b0;

   // Values written into the inputs right after acceptance
   logic [DW-1:0] scrTx = '0;
   logic [2:0]    scrSel = 3'd0;

   spi_master_multi #(.DATA_W(DW), .NUM_SS(NSS)) dut (
      .GCLK        (GCLK),
      .RST         (RST),
      .st          (st),
      .cpol        (cpol),
      .cpha        (cpha),
      .lsb_first   (lsb_first),
      .clk_div     (clk_div),
      .ss_sel      (ss_sel),
      .tx_data     (tx_data),
      .rx_data     (rx_data),
      .busy        (busy),
      .done        (done),
      .MASTER_SCLK (MASTER_SCLK),
      .MASTER_MOSI (MASTER_MOSI),
      .MASTER_MISO (MASTER_MISO),
      .MASTER_SS   (MASTER_SS)
   );

   // 100 MHz system clock
   always #5 GCLK = ~GCLK;

   assign MASTER_MISO = loopMode ? MASTER_MOSI : slvMiso;

   // k-th bit on the wire for a given word and bit order
   function automatic logic pickBit(input logic [DW-1:0] w, input int k, input logic lsb);
      pickBit = lsb ? w[k] : w[DW-1-k];
   endfunction

   // Expected select lines: everything high except a valid chosen slave
   function automatic logic [NSS-1:0] ssModel(input logic [2:0] sel);
      ssModel = '1;
      if (int'(sel) < NSS) ssModel[sel] = 1'b0;
   endfunction

   // Behavioural SPI slave. A new transfer starts when busy rises; each
   // SCLK change is numbered, odd numbers being leading edges. The slave
   // samples MOSI on the capture edge of the mode and presents its next
   // MISO bit on the launch edge (or at select time for cpha=0).
   always @(busy or MASTER_SCLK) begin
      if (busy === 1'b1 && prevBusy !== 1'b1) begin
         sclkEdges = 0;
         slvSent = 0;
         mosiCnt = 0;
         mosiSeen = '0;
         if (!slvCpha) begin
            slvMiso = pickBit(slvWord, 0, slvLsb);
            slvSent = 1;
         end
      end else if (busy === 1'b1 && MASTER_SCLK !== prevSclk) begin
         sclkEdges++;
         isLeading = (sclkEdges % 2) == 1;
         if ((slvCpha ? !isLeading : isLeading) && mosiCnt < DW) begin
            if (slvLsb) mosiSeen[mosiCnt] = MASTER_MOSI;
            else mosiSeen[DW-1-mosiCnt] = MASTER_MOSI;
            mosiCnt++;
         end
         if ((slvCpha ? isLeading : !isLeading) && slvSent < DW) begin
            slvMiso = pickBit(slvWord, slvSent, slvLsb);
            slvSent++;
         end
      end
      prevBusy = busy;
      prevSclk = MASTER_SCLK;
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Run one transfer and check it. Returns sampling the done cycle when
   // holdSt is set (st left high), otherwise one cycle after done.
   task automatic applyStimulus(input logic [DW-1:0] tx, input logic pol, input logic pha,
                                input logic lsb, input logic [7:0] div, input logic [2:0] sel,
                                input logic loop, input logic [DW-1:0] sword, input logic holdSt);
      int h;
      int expDone;
      int cyc;
      int doneCyc;
      int ssBad;
      int rxBad;
      logic [DW-1:0] prevRx;
      logic [NSS-1:0] expSs;
      @(negedge GCLK);
      st = 1'b0;
      tx_data = tx;
      cpol = pol;
      cpha = pha;
      lsb_first = lsb;
      clk_div = div;
      ss_sel = sel;
      loopMode = loop;
      slvWord = sword;
      slvCpha = pha;
      slvLsb = lsb;
      repeat (2) @(negedge GCLK);
      prevRx = rx_data;
      st = 1'b1;
      @(posedge GCLK);
      #1;
      if (!holdSt) st = 1'b0;
      scrTx = DW'($urandom);
      scrSel = 3'($urandom_range(0, 7));
      tx_data = scrTx;
      ss_sel = scrSel;
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      lsb_first = 1'($urandom);
      clk_div = 8'($urandom_range(0, 3));
      checkOutput("acceptBusy", busy, 1);
      h = (div == 8'd0) ? 1 : int'(div);
      expDone = 1 + (2 * DW + 2) * h;
      expSs = ssModel(sel);
      cyc = 1;
      doneCyc = 0;
      ssBad = 0;
      rxBad = 0;
      while (doneCyc == 0 && cyc < 2000) begin
         if (busy === 1'b1 && MASTER_SS !== expSs) ssBad++;
         if (done === 1'b1) begin
            doneCyc = cyc;
         end else begin
            if (rx_data !== prevRx) rxBad++;
            @(posedge GCLK);
            #1;
            cyc++;
         end
      end
      checkOutput("doneCycle", doneCyc, expDone);
      checkOutput("busyAtDone", busy, 0);
      checkOutput("ssWhileBusy", ssBad, 0);
      checkOutput("rxHold", rxBad, 0);
      checkOutput("sclkEdges", sclkEdges, 2 * DW);
      checkOutput("rxData", rx_data, loop ? tx : sword);
      checkOutput("mosiWord", mosiSeen, tx);
      if (!holdSt) begin
         @(posedge GCLK);
         #1;
         checkOutput("donePulse", done, 0);
         checkOutput("sclkIdle", MASTER_SCLK, cpol);
         checkOutput("mosiIdle", MASTER_MOSI, 0);
         checkOutput("ssIdle", MASTER_SS, {NSS{1'b1}});
      end
   endtask

   initial begin
      int doneSeen;
      int cyc;
      logic [DW-1:0] secondTx;
      logic [2:0] secondSel;

      // Asynchronous reset: outputs settle before any clock edge
      #2 RST = 1'b1;
      #1;
      $display("[TB] reset values");
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstRx", rx_data, 0);
      checkOutput("rstSclk", MASTER_SCLK, 0);
      checkOutput("rstMosi", MASTER_MOSI, 0);
      checkOutput("rstSs", MASTER_SS, 4'hF);
      repeat (3) @(negedge GCLK);
      RST = 1'b0;

      // Mode 0 loopback, half period 2, slave 1
      $display("[TB] mode 0 loopback");
      applyStimulus(8'hA5, 0, 0, 0, 8'd2, 3'd1, 1, 8'h00, 0);

      // All modes and both bit orders against a slave returning 0x3C
      $display("[TB] mode sweep");
      for (int m = 0; m < 4; m++) begin
         for (int l = 0; l < 2; l++) begin
            applyStimulus(DW'($urandom), m[1], m[0], l[0], 8'd1 + 8'(l), 3'(m), 0, 8'h3C, 0);
         end
      end

      // clk_div 0 and 1 behave the same
      $display("[TB] clk_div 0 vs 1");
      applyStimulus(8'h96, 1, 0, 0, 8'd0, 3'd2, 0, 8'h69, 0);
      applyStimulus(8'h96, 1, 0, 0, 8'd1, 3'd2, 0, 8'h69, 0);

      // Out-of-range slave index: no select, transfer still runs
      $display("[TB] ss_sel out of range");
      applyStimulus(8'h4B, 0, 1, 1, 8'd2, 3'd5, 0, 8'hD2, 0);

      // st held high: one transfer, then the next starts right after done
      $display("[TB] st held high");
      applyStimulus(8'h5A, 0, 0, 0, 8'd2, 3'd2, 1, 8'h00, 1);
      secondTx = scrTx;
      secondSel = scrSel;
      checkOutput("gapSs", MASTER_SS, 4'hF);
      checkOutput("gapBusy", busy, 0);
      @(posedge GCLK);
      #1;
      st = 1'b0;
      checkOutput("reaccept", busy, 1);
      checkOutput("reacceptSs", MASTER_SS, ssModel(secondSel));
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         @(posedge GCLK);
         #1;
         cyc++;
      end
      checkOutput("secondDone", done, 1);
      checkOutput("secondRx", rx_data, secondTx);

      // Random transfers
      $display("[TB] random transfers");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       1'($urandom), DW'($urandom), 0);
      end

      // Reset in the middle of a transfer
      $display("[TB] reset mid-transfer");
      @(negedge GCLK);
      RST = 1'b1;
      @(negedge GCLK);
      RST = 1'b0;
      tx_data = 8'hA5;
      cpol = 1'b1;
      cpha = 1'b0;
      lsb_first = 1'b0;
      clk_div = 8'd2;
      ss_sel = 3'd0;
      loopMode = 1'b1;
      repeat (2) @(negedge GCLK);
      st = 1'b1;
      @(posedge GCLK);
      #1;
      st = 1'b0;
      repeat (9) @(posedge GCLK);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortDone", done, 0);
      checkOutput("abortRx", rx_data, 0);
      checkOutput("abortSclk", MASTER_SCLK, 0);
      checkOutput("abortMosi", MASTER_MOSI, 0);
      checkOutput("abortSs", MASTER_SS, 4'hF);
      #3;
      RST = 1'b0;
      doneSeen = 0;
      repeat (60) begin
         @(posedge GCLK);
         #1;
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("abortNoDone", doneSeen, 0);
      checkOutput("abortRxStays", rx_data, 0);
      checkOutput("abortIdle", busy, 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
